axi_wr_slave_mem: RTL

AXI3 write-path slave that directly consumes the master-side AW/W channels and produces the B channel of the team's AXI interface.
- Accepts one write burst at a time.
- Commits byte-strobed beats into an internal word-addressed memory.
- Returns one write response per burst.
- Sits as the downstream endpoint behind the interface's master clocking block in block-level benches and simple SoC stubs.
- Exposes a registered debug read port for scoreboard checks.

---
 rtl/axi_wr_slave_mem.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/axi_wr_slave_mem.sv
// AXI3 write-path slave: accepts one AW/W burst at a time into a word-addressed memory and returns one B per burst.
// Optional `define AXI_WR_SLAVE_BACKPRESSURE_EN throttles WREADY with an 8-bit LFSR during the data phase.
module axi_wr_slave_mem #(
  parameter int AXI_ADRESS_WIDTH = 32,
  parameter int AXI_DATA_WIDTH   = 32,
  parameter int AID_WIDTH        = 4,
  parameter int MEM_DEPTH        = 1024
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [AID_WIDTH-1:0]          AWID,
  input  logic [AXI_ADRESS_WIDTH-1:0]   AWADDR,
  input  logic [3:0]                    AWLEN,
  input  logic [2:0]                    AWSIZE,
  input  logic [1:0]                    AWBURST,
  input  logic [1:0]                    AWLOCK,
  input  logic [3:0]                    AWCACHE,
  input  logic [2:0]                    AWPROT,
  input  logic                          AWVALID,
  output logic                          AWREADY,
  input  logic [AID_WIDTH-1:0]          WID,
  input  logic [AXI_DATA_WIDTH-1:0]     WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0]   WSTRB,
  input  logic                          WLAST,
  input  logic                          WVALID,
  output logic                          WREADY,
  output logic [AID_WIDTH-1:0]          BID,
  output logic [1:0]                    BRESP,
  output logic                          BVALID,
  input  logic                          BREADY,
  input  logic [$clog2(MEM_DEPTH)-1:0]  DBG_RADDR,
  output logic [AXI_DATA_WIDTH-1:0]     DBG_RDATA
);
  localparam int STRB_W   = AXI_DATA_WIDTH / 8;
  localparam int SIZE_MAX = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(MEM_DEPTH);
  localparam int AW       = AXI_ADRESS_WIDTH;

  // Handshake: a transfer happens on the rising edge where valid and ready are both high;
  // valid holds until then, and every ready/valid driven here is registered.
  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_RESP} state_e;

  state_e                      state_q, state_d;
  logic                        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [AID_WIDTH-1:0]        bid_q, bid_d, id_q, id_d;
  logic [1:0]                  bresp_q, bresp_d, burst_q, burst_d;
  logic [AW-1:0]               addr_q, addr_d;
  logic [3:0]                  len_q, len_d, beat_q, beat_d;
  logic [2:0]                  size_q, size_d;
  logic                        cfg_err_q, cfg_err_d, slverr_q, slverr_d, decerr_q, decerr_d;
  logic [AXI_DATA_WIDTH-1:0]   dbg_rdata_q, dbg_rdata_d;
  logic [AXI_DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  logic                        aw_hs, w_hs, b_hs, last_beat, oob, mem_we;
  logic                        aw_len_ok, aw_unaligned, aw_cfg_err;
  logic [AW-1:0]               incr, wrap_mask, next_addr, word_full;
  logic [IDX_W-1:0]            w_idx;
  logic                        unused_inputs;

  assign unused_inputs = ^{AWLOCK, AWCACHE, AWPROT};

  assign aw_hs     = AWVALID & awready_q;
  assign w_hs      = WVALID & wready_q;
  assign b_hs      = BREADY & bvalid_q;
  assign last_beat = (beat_q == len_q);

  assign aw_len_ok    = (AWLEN == 4'd1) || (AWLEN == 4'd3) || (AWLEN == 4'd7) || (AWLEN == 4'd15);
  assign aw_unaligned = (AWADDR & ((AW'(1) << AWSIZE) - AW'(1))) != '0;
  assign aw_cfg_err   = (AWBURST == 2'b11) || (AWSIZE > 3'(SIZE_MAX)) ||
                        ((AWBURST == 2'b10) && (!aw_len_ok || aw_unaligned));

  assign incr      = AW'(1) << size_q;
  assign wrap_mask = ((AW'(len_q) + AW'(1)) << size_q) - AW'(1);
  assign word_full = addr_q >> SIZE_MAX;
  assign oob       = word_full >= AW'(MEM_DEPTH);
  assign w_idx     = word_full[IDX_W-1:0];
  assign mem_we    = w_hs & ~cfg_err_q & ~oob;

  always_comb begin
    case (burst_q)
      2'b00:   next_addr = addr_q;
      2'b10:   next_addr = (addr_q & ~wrap_mask) | ((addr_q + incr) & wrap_mask);
      default: next_addr = addr_q + incr;
    endcase
  end

`ifdef AXI_WR_SLAVE_BACKPRESSURE_EN
  logic [7:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) lfsr_q <= 8'hA5;
    else        lfsr_q <= lfsr_d;
  end
`endif

  always_comb begin
    state_d   = state_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    beat_d    = beat_q;
    cfg_err_d = cfg_err_q;
    slverr_d  = slverr_q;
    decerr_d  = decerr_q;
    case (state_q)
      ST_IDLE: begin
        if (aw_hs) begin
          id_d      = AWID;
          addr_d    = AWADDR;
          len_d     = AWLEN;
          size_d    = AWSIZE;
          burst_d   = AWBURST;
          beat_d    = 4'd0;
          cfg_err_d = aw_cfg_err;
          slverr_d  = aw_cfg_err;
          decerr_d  = 1'b0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_hs) begin
          beat_d = beat_q + 4'd1;
          addr_d = next_addr;
          if (WID != id_q)        slverr_d = 1'b1;
          if (WLAST != last_beat) slverr_d = 1'b1;
          if (oob)                decerr_d = 1'b1;
          // Burst length is fixed by AWLEN regardless of where WLAST shows up.
          if (last_beat) begin
            state_d = ST_RESP;
            bid_d   = id_q;
            bresp_d = decerr_d ? 2'b11 : (slverr_d ? 2'b10 : 2'b00);
          end
        end
      end
      ST_RESP: begin
        if (b_hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    awready_d = (state_d == ST_IDLE);
    bvalid_d  = (state_d == ST_RESP);
`ifdef AXI_WR_SLAVE_BACKPRESSURE_EN
    wready_d  = (state_d == ST_DATA) && lfsr_d[0];
`else
    wready_d  = (state_d == ST_DATA);
`endif
    dbg_rdata_d = mem[DBG_RADDR];
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q     <= ST_IDLE;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= 2'b00;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= 4'd0;
      size_q      <= 3'd0;
      burst_q     <= 2'b00;
      beat_q      <= 4'd0;
      cfg_err_q   <= 1'b0;
      slverr_q    <= 1'b0;
      decerr_q    <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bid_q       <= bid_d;
      bresp_q     <= bresp_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      beat_q      <= beat_d;
      cfg_err_q   <= cfg_err_d;
      slverr_q    <= slverr_d;
      decerr_q    <= decerr_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // Memory contents survive reset; only the handshake path is cleared.
  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (WSTRB[b]) mem[w_idx][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  assign AWREADY   = awready_q;
  assign WREADY    = wready_q;
  assign BVALID    = bvalid_q;
  assign BID       = bid_q;
  assign BRESP     = bresp_q;
  assign DBG_RDATA = dbg_rdata_q;
endmodule
